bus_arbiter: RTL and testbench

- Two-master arbiter for the 16-bit addr/data/rw/valid register bus.
- Lets the UART bridge (master 0) and a second host such as an on-chip sequencer (master 1) share one core chain.
- Buffers each master's single-cycle requests in a small FIFO and issues one transaction at a time, round-robin.
- Waits for the transaction to return at the end of the core chain, then routes the response back to the master that issued it.

---
 rtl/bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master arbiter for the 16-bit addr/data/rw/valid register bus.
// Each master's single-cycle requests are queued in a small FIFO. The arbiter
// issues one transaction at a time, alternating between masters (round-robin)
// when both have work queued. It then waits for the transaction to come back
// from the end of the core chain and routes that response to the master that
// issued it.
// Optional feature: define BUS_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT_CYCLES. On expiry the master receives a 16'hFFFF response and
// timeout_o pulses for one cycle.

module bus_arbiter #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0 (UART bridge)
  input  logic [15:0] m0_addr_i,
  input  logic [15:0] m0_data_i,
  input  logic        m0_rw_i,
  input  logic        m0_valid_i,
  output logic [15:0] m0_data_o,
  output logic        m0_rw_o,
  output logic        m0_valid_o,
  output logic        m0_drop_o,
  // master 1 (second host)
  input  logic [15:0] m1_addr_i,
  input  logic [15:0] m1_data_i,
  input  logic        m1_rw_i,
  input  logic        m1_valid_i,
  output logic [15:0] m1_data_o,
  output logic        m1_rw_o,
  output logic        m1_valid_o,
  output logic        m1_drop_o,
  // issued transaction towards the core chain
  output logic [15:0] bus_addr_o,
  output logic [15:0] bus_data_o,
  output logic        bus_rw_o,
  output logic        bus_valid_o,
  // transaction returning from the end of the core chain
  input  logic [15:0] ret_addr_i,
  input  logic [15:0] ret_data_i,
  input  logic        ret_rw_i,
  input  logic        ret_valid_i,
  // status
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        rw;
  } req_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Request FIFOs (index 0 = master 0, index 1 = master 1)
  // ---------------------------------------------------------------------------
  req_t          in_req   [2];
  logic [1:0]    in_valid;
  req_t          mem_q    [2][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [CW-1:0] cnt_q    [2];
  logic [1:0]    not_empty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic [1:0]    drop_d;
  logic [1:0]    drop_q;

  // The returned address is deliberately not compared with the issued one.
  logic          unused_ret_addr;
  assign unused_ret_addr = ^ret_addr_i;

  assign in_req[0] = '{addr: m0_addr_i, data: m0_data_i, rw: m0_rw_i};
  assign in_req[1] = '{addr: m1_addr_i, data: m1_data_i, rw: m1_rw_i};
  assign in_valid  = {m1_valid_i, m0_valid_i};

  // ---------------------------------------------------------------------------
  // Arbiter state
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        grant_q, grant_d;            // master that owns the outstanding transaction
  logic        last_grant_q, last_grant_d;  // master granted most recently
  logic        grant_req;
  logic        grant_sel;
  req_t        head;

  logic [15:0] bus_addr_q, bus_addr_d;
  logic [15:0] bus_data_q, bus_data_d;
  logic        bus_rw_q, bus_rw_d;
  logic        bus_valid_q, bus_valid_d;

  logic [1:0][15:0] rsp_data_q, rsp_data_d;
  logic [1:0]       rsp_rw_q, rsp_rw_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Pick the next master: the only non-empty one, or the one not granted last.
  always_comb begin
    for (int m = 0; m < 2; m++) not_empty[m] = (cnt_q[m] != '0);
    grant_req = |not_empty;
    if (&not_empty) grant_sel = ~last_grant_q;
    else            grant_sel = not_empty[1];
    head = mem_q[grant_sel][rd_ptr_q[grant_sel]];
  end

  // Pop on a grant; push unless full, where a simultaneous pop frees the slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pop    = '0;
    push   = '0;
    drop_d = '0;
    if (state_q == IDLE && grant_req) pop[grant_sel] = 1'b1;
    for (int m = 0; m < 2; m++) begin
      push[m]   = in_valid[m] && ((cnt_q[m] != FULL_CNT) || pop[m]);
      drop_d[m] = in_valid[m] && !push[m];
    end
  end

  // FIFO pointers, occupancy counters and drop pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        wr_ptr_q[m] <= '0;
        rd_ptr_q[m] <= '0;
        cnt_q[m]    <= '0;
      end
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
      for (int m = 0; m < 2; m++) begin
        if (push[m]) wr_ptr_q[m] <= wr_ptr_q[m] + PW'(1);
        if (pop[m])  rd_ptr_q[m] <= rd_ptr_q[m] + PW'(1);
        cnt_q[m] <= cnt_q[m] + CW'(push[m]) - CW'(pop[m]);
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the counters define which entries are valid, so stale contents are never read.
    for (int m = 0; m < 2; m++) begin
      if (push[m]) mem_q[m][wr_ptr_q[m]] <= in_req[m];
    end
  end

  // Next-state and output logic for the IDLE/WAIT transaction FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    bus_addr_d   = bus_addr_q;
    bus_data_d   = bus_data_q;
    bus_rw_d     = bus_rw_q;
    bus_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_rw_d     = rsp_rw_q;
    rsp_valid_d  = '0;
`ifdef BUS_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // A return arriving in IDLE is a stray and is ignored.
        if (grant_req) begin
          bus_addr_d   = head.addr;
          bus_data_d   = head.data;
          bus_rw_d     = head.rw;
          bus_valid_d  = 1'b1;
          grant_d      = grant_sel;
          last_grant_d = grant_sel;
          state_d      = WAIT;
`ifdef BUS_ARB_TIMEOUT_EN
          wait_cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (ret_valid_i) begin
          rsp_data_d[grant_q]  = ret_data_i;
          rsp_rw_d[grant_q]    = ret_rw_i;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = IDLE;
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          rsp_data_d[grant_q]  = 16'hFFFF;
          rsp_rw_d[grant_q]    = bus_rw_q;
          rsp_valid_d[grant_q] = 1'b1;
          timeout_d            = 1'b1;
          state_d              = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;  // master 0 wins the first tie
      bus_addr_q   <= '0;
      bus_data_q   <= '0;
      bus_rw_q     <= 1'b0;
      bus_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_rw_q     <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      bus_addr_q   <= bus_addr_d;
      bus_data_q   <= bus_data_d;
      bus_rw_q     <= bus_rw_d;
      bus_valid_q  <= bus_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_rw_q     <= rsp_rw_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  // WAIT-cycle counter and timeout pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign m0_data_o   = rsp_data_q[0];
  assign m0_rw_o     = rsp_rw_q[0];
  assign m0_valid_o  = rsp_valid_q[0];
  assign m0_drop_o   = drop_q[0];
  assign m1_data_o   = rsp_data_q[1];
  assign m1_rw_o     = rsp_rw_q[1];
  assign m1_valid_o  = rsp_valid_q[1];
  assign m1_drop_o   = drop_q[1];
  assign bus_addr_o  = bus_addr_q;
  assign bus_data_o  = bus_data_q;
  assign bus_rw_o    = bus_rw_q;
  assign bus_valid_o = bus_valid_q;
  assign busy_o      = (state_q == WAIT);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (default build, FIFO_DEPTH = 4).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_rw_i, m0_valid_i, m1_rw_i, m1_valid_i;
  logic [15:0] m0_data_o, m1_data_o;
  logic        m0_rw_o, m0_valid_o, m0_drop_o;
  logic        m1_rw_o, m1_valid_o, m1_drop_o;
  logic [15:0] bus_addr_o, bus_data_o;
  logic        bus_rw_o, bus_valid_o;
  logic [15:0] ret_addr_i, ret_data_i;
  logic        ret_rw_i, ret_valid_i;
  logic        busy_o, timeout_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m0_addr_i  (m0_addr_i),
    .m0_data_i  (m0_data_i),
    .m0_rw_i    (m0_rw_i),
    .m0_valid_i (m0_valid_i),
    .m0_data_o  (m0_data_o),
    .m0_rw_o    (m0_rw_o),
    .m0_valid_o (m0_valid_o),
    .m0_drop_o  (m0_drop_o),
    .m1_addr_i  (m1_addr_i),
    .m1_data_i  (m1_data_i),
    .m1_rw_i    (m1_rw_i),
    .m1_valid_i (m1_valid_i),
    .m1_data_o  (m1_data_o),
    .m1_rw_o    (m1_rw_o),
    .m1_valid_o (m1_valid_o),
    .m1_drop_o  (m1_drop_o),
    .bus_addr_o (bus_addr_o),
    .bus_data_o (bus_data_o),
    .bus_rw_o   (bus_rw_o),
    .bus_valid_o(bus_valid_o),
    .ret_addr_i (ret_addr_i),
    .ret_data_i (ret_data_i),
    .ret_rw_i   (ret_rw_i),
    .ret_valid_i(ret_valid_i),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_m0(input logic v, input logic [15:0] a, input logic [15:0] d, input logic rw);
    m0_valid_i = v; m0_addr_i = a; m0_data_i = d; m0_rw_i = rw;
  endtask

  task automatic set_m1(input logic v, input logic [15:0] a, input logic [15:0] d, input logic rw);
    m1_valid_i = v; m1_addr_i = a; m1_data_i = d; m1_rw_i = rw;
  endtask

  // Present one return transaction for a single edge.
  task automatic ret(input logic [15:0] d, input logic rw);
    ret_valid_i = 1'b1; ret_data_i = d; ret_rw_i = rw; ret_addr_i = 16'h5A5A;
    @(negedge clk);
    ret_valid_i = 1'b0; ret_data_i = '0; ret_rw_i = 1'b0; ret_addr_i = '0;
  endtask

  // Wait (bounded) for a transaction to be outstanding.
  task automatic wait_busy(input string tag);
    int n = 0;
    while (busy_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy_o, 1);
  endtask

  function automatic logic any_out();
    return |{m0_data_o, m0_rw_o, m0_valid_o, m0_drop_o,
             m1_data_o, m1_rw_o, m1_valid_o, m1_drop_o,
             bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o, busy_o, timeout_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_addr;
    logic        exp_m;
    int          held;

    rst_n = 1'b0;
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    ret_valid_i = 0; ret_data_i = 0; ret_rw_i = 0; ret_addr_i = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs_zero", any_out(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", busy_o, 0);

    // Both masters strobe together three times: issue order m0,m1,m0,m1,m0,m1.
    for (int k = 0; k < 3; k++) begin
      set_m0(1, 16'h0100 + 16'(k), 16'h0, 0);
      set_m1(1, 16'h0200 + 16'(k), 16'h0, 0);
      @(negedge clk);
    end
    set_m0(0, 0, 0, 0);
    set_m1(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      exp_m    = 1'(i % 2);
      exp_addr = (exp_m ? 16'h0200 : 16'h0100) + 16'(i / 2);
      wait_busy("rr_busy");
      check("rr_bus_addr", bus_addr_o, exp_addr);
      ret(16'hA000 + 16'(i), 0);
      check("rr_owner_valid", exp_m ? m1_valid_o : m0_valid_o, 1);
      check("rr_other_valid", exp_m ? m0_valid_o : m1_valid_o, 0);
      check("rr_owner_data", exp_m ? m1_data_o : m0_data_o, 16'hA000 + 16'(i));
    end

    // m0 read of 0x0009: latency, single-cycle bus_valid, response routing.
    set_m0(1, 16'h0009, 16'h0, 0);
    @(negedge clk);
    set_m0(0, 0, 0, 0);
    check("lat_no_issue_yet", bus_valid_o, 0);
    @(negedge clk);
    check("lat_bus_valid", bus_valid_o, 1);
    check("lat_bus_addr", bus_addr_o, 16'h0009);
    check("lat_bus_rw", bus_rw_o, 0);
    check("lat_busy", busy_o, 1);
    @(negedge clk);
    check("wait_bus_valid_low", bus_valid_o, 0);
    @(negedge clk);
    ret(16'h1234, 0);
    check("rd_m0_valid", m0_valid_o, 1);
    check("rd_m0_data", m0_data_o, 16'h1234);
    check("rd_m0_rw", m0_rw_o, 0);
    check("rd_m1_valid", m1_valid_o, 0);
    check("rd_not_busy", busy_o, 0);
    @(negedge clk);
    check("rsp_valid_single", m0_valid_o, 0);
    check("rsp_data_hold", m0_data_o, 16'h1234);

    // m1 overflows its FIFO while m0 is outstanding.
    set_m0(1, 16'h0300, 16'h0, 0);
    @(negedge clk);
    set_m0(0, 0, 0, 0);
    wait_busy("ovf_busy");
    check("ovf_m0_addr", bus_addr_o, 16'h0300);
    for (int k = 0; k < 5; k++) begin
      set_m1(1, 16'h0400 + 16'(k), 16'h0, 0);
      @(negedge clk);
      check("ovf_drop", m1_drop_o, (k == 4) ? 1 : 0);
    end
    set_m1(0, 0, 0, 0);
    @(negedge clk);
    check("ovf_drop_once", m1_drop_o, 0);
    ret(16'hB300, 0);
    check("ovf_m0_valid", m0_valid_o, 1);
    check("ovf_m0_data", m0_data_o, 16'hB300);
    // Push into the full FIFO on the same edge it pops: push must be accepted.
    set_m1(1, 16'h0404, 16'h0, 0);
    @(negedge clk);
    set_m1(0, 0, 0, 0);
    check("full_pushpop_no_drop", m1_drop_o, 0);
    check("full_pushpop_issue", bus_addr_o, 16'h0400);
    for (int k = 0; k < 5; k++) begin
      wait_busy("drain_busy");
      check("drain_addr", bus_addr_o, 16'h0400 + 16'(k));
      ret(16'hC400 + 16'(k), 0);
      check("drain_m1_valid", m1_valid_o, 1);
      check("drain_m1_data", m1_data_o, 16'hC400 + 16'(k));
      check("drain_m0_valid", m0_valid_o, 0);
    end

    // m1 write 0x0000 <= 0x0001.
    set_m1(1, 16'h0000, 16'h0001, 1);
    @(negedge clk);
    set_m1(0, 0, 0, 0);
    wait_busy("wr_busy");
    check("wr_bus_rw", bus_rw_o, 1);
    check("wr_bus_data", bus_data_o, 16'h0001);
    check("wr_bus_addr", bus_addr_o, 16'h0000);
    ret(16'h0001, 1);
    check("wr_m1_valid", m1_valid_o, 1);
    check("wr_m1_rw", m1_rw_o, 1);
    check("wr_m1_data", m1_data_o, 16'h0001);
    check("wr_m0_valid", m0_valid_o, 0);

    // No return: WAIT persists with no timeout; queue two more entries.
    set_m0(1, 16'h0500, 16'h0, 0);
    @(negedge clk);
    set_m0(0, 0, 0, 0);
    wait_busy("hang_busy");
    set_m0(1, 16'h0600, 16'h0, 0);
    @(negedge clk);
    set_m0(1, 16'h0601, 16'h0, 0);
    @(negedge clk);
    set_m0(0, 0, 0, 0);
    held = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy_o === 1'b1 && timeout_o === 1'b0) held++;
    end
    check("hang_busy_held", held, 40);

    // Reset mid-transaction with two entries queued.
    rst_n = 1'b0;
    #1;
    check("midrst_outputs_zero", any_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ret(16'hDEAD, 0);
    check("stray_m0_valid", m0_valid_o, 0);
    check("stray_m1_valid", m1_valid_o, 0);
    check("stray_not_busy", busy_o, 0);
    @(negedge clk);
    check("queue_flushed", busy_o, 0);
    check("queue_flushed_bus", bus_valid_o, 0);
    set_m1(1, 16'h0700, 16'h0, 0);
    @(negedge clk);
    set_m1(0, 0, 0, 0);
    check("post_rst_lat", bus_valid_o, 0);
    @(negedge clk);
    check("post_rst_issue", bus_valid_o, 1);
    check("post_rst_addr", bus_addr_o, 16'h0700);
    ret(16'h7777, 0);
    check("post_rst_m1_valid", m1_valid_o, 1);
    check("post_rst_m1_data", m1_data_o, 16'h7777);
    check("no_timeout", timeout_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
